// File: rtl/freq_calc_multi_if.sv
// Handshake and result bus for the multi-channel theoretical-frequency calculator.
// master: requester side (drives start/key_in); slave: calculator side.
interface freq_calc_multi_if #(
    parameter int unsigned KEY_W  = 8,
    parameter int unsigned OUT_W  = 14,
    parameter int unsigned NUM_CH = 4
);
    logic                      start;
    logic [NUM_CH*KEY_W-1:0]   key_in;
    logic                      busy;
    logic                      done;
    logic [NUM_CH*OUT_W-1:0]   li_lun_zhi;
    logic [NUM_CH-1:0]         sat;

    modport master (
        output start, key_in,
        input  busy, done, li_lun_zhi, sat
    );

    modport slave (
        input  start, key_in,
        output busy, done, li_lun_zhi, sat
    );
endinterface

// File: rtl/freq_calc_multi.sv
// Multi-channel theoretical-frequency calculator: f_out = (F_REF * key) >> KEY_W per channel,
// computed with one time-shared shift-add multiplier, saturating to OUT_W bits.
// Optional build macro FREQ_CALC_ROUND_EN selects round-half-up instead of truncation.
module freq_calc_multi #(
    parameter int unsigned KEY_W  = 8,
    parameter int unsigned F_REF  = 10000,
    parameter int unsigned OUT_W  = 14,
    parameter int unsigned NUM_CH = 4
) (
    input  logic                 clk_10k,
    input  logic                 rst,
    freq_calc_multi_if.slave     bus
);
    localparam int unsigned AccW = $clog2(F_REF + 1) + KEY_W;
    // One spare bit so the rounding offset can never wrap the sum.
    localparam int unsigned SumW = AccW + 1;
    localparam int unsigned QW   = SumW - KEY_W;
    localparam int unsigned CntW = $clog2(KEY_W + 1);
    localparam int unsigned ChW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

`ifdef FREQ_CALC_ROUND_EN
    localparam logic [SumW-1:0] RoundC = SumW'(1) << (KEY_W - 1);
`else
    localparam logic [SumW-1:0] RoundC = '0;
`endif

    typedef enum logic [1:0] {StIdle, StLoad, StMul, StStore} state_e;

    state_e                     state_q;
    logic [NUM_CH*KEY_W-1:0]    snap_q;
    logic [ChW-1:0]             ch_q;
    logic [KEY_W-1:0]           mplier_q;
    logic [CntW-1:0]            cnt_q;
    logic [AccW-1:0]            acc_q;
    logic [NUM_CH*OUT_W-1:0]    res_q;
    logic [NUM_CH-1:0]          sat_q;
    logic                       busy_q;
    logic                       done_q;

    logic [AccW-1:0]            addend;
    logic [SumW-1:0]            sum_ext;
    logic [QW-1:0]              q;
    logic [QW+OUT_W-1:0]        q_ext;
    logic                       over;
    logic [OUT_W-1:0]           res_val;

    // Partial product for the current bit and the clipped quotient written in STORE.
    always_comb begin
        addend  = AccW'(F_REF) << cnt_q;
        sum_ext = {1'b0, acc_q} + RoundC;
        q       = QW'(sum_ext >> KEY_W);
        q_ext   = {{OUT_W{1'b0}}, q};
        over    = (q_ext >> OUT_W) != '0;
        res_val = over ? {OUT_W{1'b1}} : q_ext[OUT_W-1:0];
    end

    // Sweep FSM: snapshot keys, then LOAD/MUL/STORE each channel in turn.
    always_ff @(posedge clk_10k or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            snap_q   <= '0;
            ch_q     <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            res_q    <= '0;
            sat_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        snap_q  <= bus.key_in;
                        ch_q    <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    acc_q    <= '0;
                    mplier_q <= snap_q[ch_q*KEY_W +: KEY_W];
                    cnt_q    <= '0;
                    state_q  <= StMul;
                end
                StMul: begin
                    if (mplier_q[0]) begin
                        acc_q <= acc_q + addend;
                    end
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CntW'(1);
                    if (cnt_q == CntW'(KEY_W - 1)) begin
                        state_q <= StStore;
                    end
                end
                StStore: begin
                    res_q[ch_q*OUT_W +: OUT_W] <= res_val;
                    sat_q[ch_q]                <= over;
                    if (ch_q == ChW'(NUM_CH - 1)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        ch_q    <= ch_q + ChW'(1);
                        state_q <= StLoad;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.li_lun_zhi = res_q;
    assign bus.sat        = sat_q;
endmodule

// File: tb/tb_freq_calc_multi.sv
// Self-checking bench for freq_calc_multi: three configurations (defaults, OUT_W=13,
// NUM_CH=1/KEY_W=12) driven by directed sweeps, results checked against a scoreboard.
module tb_freq_calc_multi;
    localparam int unsigned F_REF = 10000;

    logic clk_10k = 1'b0;
    logic rst     = 1'b0;
    always #5 clk_10k = ~clk_10k;

    freq_calc_multi_if #(.KEY_W(8),  .OUT_W(14), .NUM_CH(4)) b0 ();
    freq_calc_multi_if #(.KEY_W(8),  .OUT_W(13), .NUM_CH(4)) b1 ();
    freq_calc_multi_if #(.KEY_W(12), .OUT_W(14), .NUM_CH(1)) b2 ();

    freq_calc_multi #(.KEY_W(8), .F_REF(F_REF), .OUT_W(14), .NUM_CH(4)) dut0 (
        .clk_10k (clk_10k),
        .rst     (rst),
        .bus     (b0)
    );
    freq_calc_multi #(.KEY_W(8), .F_REF(F_REF), .OUT_W(13), .NUM_CH(4)) dut1 (
        .clk_10k (clk_10k),
        .rst     (rst),
        .bus     (b1)
    );
    freq_calc_multi #(.KEY_W(12), .F_REF(F_REF), .OUT_W(14), .NUM_CH(1)) dut2 (
        .clk_10k (clk_10k),
        .rst     (rst),
        .bus     (b2)
    );

    typedef struct {
        logic [63:0] val;
        logic [63:0] sat;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // Reference: direct product, optional half-LSB offset, then clip.
    task automatic push_exp(input int d, input logic [63:0] keys);
        exp_t   e;
        int     kw;
        int     ow;
        int     nch;
        longint key;
        longint p;
        longint qv;
        longint maxv;
        kw  = (d == 2) ? 12 : 8;
        ow  = (d == 1) ? 13 : 14;
        nch = (d == 2) ? 1 : 4;
        e.val = '0;
        e.sat = '0;
        maxv  = (longint'(1) << ow) - 1;
        for (int c = 0; c < nch; c++) begin
            key = longint'((keys >> (c * kw)) & ((64'd1 << kw) - 64'd1));
            p   = longint'(F_REF) * key;
`ifdef FREQ_CALC_ROUND_EN
            p   = p + (longint'(1) << (kw - 1));
`endif
            qv  = p >> kw;
            if (qv > maxv) begin
                qv       = maxv;
                e.sat[c] = 1'b1;
            end
            e.val = e.val | (64'(qv) << (c * ow));
        end
        sb.push_back(e);
    endtask

    task automatic set_start(input int d, input logic v);
        case (d)
            0:       b0.start = v;
            1:       b1.start = v;
            default: b2.start = v;
        endcase
    endtask

    task automatic set_keys(input int d, input logic [63:0] k);
        case (d)
            0:       b0.key_in = k[31:0];
            1:       b1.key_in = k[31:0];
            default: b2.key_in = k[11:0];
        endcase
    endtask

    function automatic logic get_done(input int d);
        return (d == 0) ? b0.done : (d == 1) ? b1.done : b2.done;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? b0.busy : (d == 1) ? b1.busy : b2.busy;
    endfunction

    function automatic logic [63:0] get_val(input int d);
        return (d == 0) ? 64'(b0.li_lun_zhi) : (d == 1) ? 64'(b1.li_lun_zhi) : 64'(b2.li_lun_zhi);
    endfunction

    function automatic logic [63:0] get_sat(input int d);
        return (d == 0) ? 64'(b0.sat) : (d == 1) ? 64'(b1.sat) : 64'(b2.sat);
    endfunction

    // Start a sweep, optionally re-pulse start and change keys at cycle 'inj', wait for done.
    task automatic sweep(input int d, input logic [63:0] keys, input int inj,
                         input logic [63:0] new_keys, output int lat, output int busy_n);
        set_keys(d, keys);
        push_exp(d, keys);
        @(negedge clk_10k);
        set_start(d, 1'b1);
        @(posedge clk_10k);
        #1;
        set_start(d, 1'b0);
        busy_n = get_busy(d) ? 1 : 0;
        lat    = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk_10k);
            #1;
            set_start(d, 1'b0);
            if (get_done(d)) begin
                lat = n;
                break;
            end
            if (get_busy(d)) busy_n++;
            if (n == inj) begin
                set_start(d, 1'b1);
                set_keys(d, new_keys);
            end
        end
    endtask

    task automatic compare_out(input int d, input string tag);
        exp_t e;
        e = sb.pop_front();
        check({tag, ".val"}, get_val(d), e.val);
        check({tag, ".sat"}, get_sat(d), e.sat);
        check({tag, ".busy_at_done"}, 64'(get_busy(d)), 64'd0);
    endtask

    initial begin
        int lat;
        int busy_n;
        int done_seen;
        b0.start = 1'b0; b1.start = 1'b0; b2.start = 1'b0;
        b0.key_in = '0;  b1.key_in = '0;  b2.key_in = '0;

        // Reset state.
        #2 rst = 1'b1;
        repeat (3) @(posedge clk_10k);
        #1;
        check("rst.val",  get_val(0), 64'd0);
        check("rst.sat",  get_sat(0), 64'd0);
        check("rst.busy", 64'(b0.busy), 64'd0);
        check("rst.done", 64'(b0.done), 64'd0);
        @(negedge clk_10k);
        rst = 1'b0;

        // Basic sweep: ch0=0 ch1=1 ch2=128 ch3=3.
        sweep(0, 64'h0380_0100, -1, 64'd0, lat, busy_n);
        check("basic.latency", 64'(lat), 64'd40);
        check("basic.busy_cycles", 64'(busy_n), 64'd40);
        compare_out(0, "basic");
        @(posedge clk_10k);
        #1;
        check("basic.done_width", 64'(b0.done), 64'd0);

        // Start and key change mid-sweep are ignored; snapshot governs the result.
        sweep(0, 64'h0000_01FF, 10, 64'hFFFF_FFFF, lat, busy_n);
        check("ignore.latency", 64'(lat), 64'd40);
        compare_out(0, "ignore");

        // Start the cycle right after done begins a new sweep.
        sweep(0, 64'h0102_0301, -1, 64'd0, lat, busy_n);
        check("b2b.latency", 64'(lat), 64'd40);
        compare_out(0, "b2b");

        // OUT_W = 13: saturation, then clearing on a following in-range sweep.
        sweep(1, 64'h0000_00FF, -1, 64'd0, lat, busy_n);
        check("sat.latency", 64'(lat), 64'd40);
        compare_out(1, "sat");
        check("sat.ch0", get_val(1) & 64'h1FFF, 64'd8191);
        sweep(1, 64'h0000_00C8, -1, 64'd0, lat, busy_n);
        compare_out(1, "unsat");

        // Single channel, KEY_W = 12.
        sweep(2, 64'h0000_0FFF, -1, 64'd0, lat, busy_n);
        check("k12.latency", 64'(lat), 64'd14);
        compare_out(2, "k12");

        // Reset mid-sweep: outputs clear at once, no done afterwards.
        b0.key_in = 32'hFFFF_FFFF;
        @(negedge clk_10k);
        b0.start = 1'b1;
        @(posedge clk_10k);
        #1;
        b0.start = 1'b0;
        repeat (15) @(posedge clk_10k);
        #1;
        rst = 1'b1;
        #1;
        check("abort.val",  get_val(0), 64'd0);
        check("abort.sat",  get_sat(0), 64'd0);
        check("abort.busy", 64'(b0.busy), 64'd0);
        check("abort.done", 64'(b0.done), 64'd0);
        @(negedge clk_10k);
        rst = 1'b0;
        done_seen = 0;
        for (int n = 0; n < 60; n++) begin
            @(posedge clk_10k);
            #1;
            if (b0.done) done_seen++;
        end
        check("abort.no_done", 64'(done_seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
